// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage load/store unit.
// Op codes, exception codes, FSM states and RAM geometry.
package mem_pkg;

  localparam int LSU_RAM_WORDS = 101;
  localparam int LSU_ADDR_W    = 10;

  typedef enum logic [2:0] {
    LSU_LB  = 3'd0,
    LSU_LBU = 3'd1,
    LSU_LH  = 3'd2,
    LSU_LHU = 3'd3,
    LSU_LW  = 3'd4,
    LSU_SB  = 3'd5,
    LSU_SH  = 3'd6,
    LSU_SW  = 3'd7
  } lsu_op_e;

  localparam logic [1:0] EXC_NONE  = 2'd0;
  localparam logic [1:0] EXC_ADEL  = 2'd1;
  localparam logic [1:0] EXC_ADES  = 2'd2;
  localparam logic [1:0] EXC_RANGE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_EXC  = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction from a RAM word.
// Selects byte/half by offset and sign/zero-extends.
module lsu_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  lsu_op_e     op,
  input  logic [1:0]  off,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = rdata[8*off +: 8];
  assign h = rdata[16*off[1] +: 16];

  // Extend the selected lane; stores return zero
  always_comb begin
    data = '0;
    case (op)
      LSU_LB:  data = {{24{b[7]}}, b};
      LSU_LBU: data = {24'd0, b};
      LSU_LH:  data = {{16{h[15]}}, h};
      LSU_LHU: data = {16'd0, h};
      LSU_LW:  data = rdata;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit in front of a synchronous data RAM.
// Aligns stores, extends loads, traps misaligned/out-of-range accesses.
module dmem_lsu
  import mem_pkg::*;
#(
  parameter int RAM_WORDS = LSU_RAM_WORDS,
  parameter int ADDR_W    = LSU_ADDR_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              flush,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              exc_valid,
  output logic [1:0]        exc_code,
  output logic [31:0]       exc_badvaddr,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  lsu_state_e state_q, state_d;

  lsu_op_e    op;
  logic       acc;
  logic       is_half;
  logic       is_word;
  logic       is_store;
  logic       mis;
  logic       oor;
  logic       fault;
  logic [1:0] fcode;

  logic       pend_valid;
  lsu_op_e    pend_op;
  logic [1:0] pend_off;
  logic [31:0] ld_data;

  assign op       = lsu_op_e'(req_op);
  assign acc      = req_valid && req_ready;
  assign is_store = req_op[2] && (req_op[1:0] != 2'd0);
  assign is_half  = (op == LSU_LH) || (op == LSU_LHU) ||
                    (op == LSU_SH);
  assign is_word  = (op == LSU_LW) || (op == LSU_SW);

  assign mis = (is_half && req_addr[0]) ||
               (is_word && (req_addr[1:0] != 2'd0));
  assign oor = {2'b00, req_addr[31:2]} >= 32'(RAM_WORDS);

  assign fault = mis || oor;
  assign fcode = mis ? (is_store ? EXC_ADES : EXC_ADEL)
                     : EXC_RANGE;

  assign ram_en   = acc && !fault;
  assign ram_addr = req_addr[ADDR_W+1:2];

  // Byte enables and replicated store data for the RAM
  always_comb begin
    ram_wen   = '0;
    ram_wdata = '0;
    if (ram_en) begin
      case (op)
        LSU_SB: begin
          ram_wen   = 4'b0001 << req_addr[1:0];
          ram_wdata = {4{req_wdata[7:0]}};
        end
        LSU_SH: begin
          ram_wen   = req_addr[1] ? 4'b1100 : 4'b0011;
          ram_wdata = {2{req_wdata[15:0]}};
        end
        LSU_SW: begin
          ram_wen   = 4'b1111;
          ram_wdata = req_wdata;
        end
        default: begin
          ram_wen   = '0;
          ram_wdata = '0;
        end
      endcase
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b1;
    case (state_q)
      S_IDLE, S_BUSY: begin
        if (acc) state_d = fault ? S_EXC : S_BUSY;
        else     state_d = S_IDLE;
      end
      S_EXC: begin
        req_ready = 1'b0;
        if (flush) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, pending response and exception registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      pend_valid   <= 1'b0;
      pend_op      <= LSU_LB;
      pend_off     <= 2'd0;
      exc_valid    <= 1'b0;
      exc_code     <= EXC_NONE;
      exc_badvaddr <= '0;
    end else begin
      state_q    <= state_d;
      pend_valid <= ram_en;
      exc_valid  <= acc && fault;
      if (ram_en) begin
        pend_op  <= op;
        pend_off <= req_addr[1:0];
      end
      if (acc && fault) begin
        exc_code     <= fcode;
        exc_badvaddr <= req_addr;
      end
    end
  end

  lsu_load_align u_align (
    .rdata (ram_rdata),
    .op    (pend_op),
    .off   (pend_off),
    .data  (ld_data)
  );

  assign rsp_valid = pend_valid && !flush;
  assign rsp_rdata = rsp_valid ? ld_data : '0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural sync RAM.
// Immediate assertions compare against hand-computed values.
module tb_dmem_lsu;
  import mem_pkg::*;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        exc_valid;
  logic [1:0]  exc_code;
  logic [31:0] exc_badvaddr;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int total;
  int passed;

  logic [31:0] mem [0:1023];

  dmem_lsu dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .flush        (flush),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .exc_valid    (exc_valid),
    .exc_code     (exc_code),
    .exc_badvaddr (exc_badvaddr),
    .ram_en       (ram_en),
    .ram_wen      (ram_wen),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM, read-before-write
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      for (int i = 0; i < 4; i++)
        if (ram_wen[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
  end

  task automatic drv(input logic v, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic fl);
    req_valid = v;
    req_op    = op;
    req_addr  = a;
    req_wdata = wd;
    flush     = fl;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0] = 32'h8899AABB;
    mem[1] = 32'h55667788;
    mem[2] = 32'h0BADF00D;
    mem[3] = 32'hCAFEBABE;
    ram_rdata = '0;
    resetn = 1'b0;
    drv(0, LSU_LB, 0, 0, 0);
    tick;
    tick;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_exc_valid", 32'(exc_valid), 0);
    chk("rst_exc_code", 32'(exc_code), 0);
    chk("rst_badvaddr", exc_badvaddr, 0);
    chk("rst_ready", 32'(req_ready), 1);
    resetn = 1'b1;
    tick;

    drv(1, LSU_LB, 32'h1, 0, 0);
    chk("lb_en", 32'(ram_en), 1);
    chk("lb_wen", 32'(ram_wen), 0);
    chk("lb_addr", 32'(ram_addr), 0);
    chk("lb_wdata", ram_wdata, 0);
    tick;
    chk("lb_valid", 32'(rsp_valid), 1);
    chk("lb_data", rsp_rdata, 32'hFFFFFFAA);

    drv(1, LSU_LBU, 32'h1, 0, 0);
    tick;
    chk("lbu_data", rsp_rdata, 32'h000000AA);
    drv(1, LSU_LH, 32'h2, 0, 0);
    tick;
    chk("lh_data", rsp_rdata, 32'hFFFF8899);
    drv(1, LSU_LHU, 32'h2, 0, 0);
    tick;
    chk("lhu_data", rsp_rdata, 32'h00008899);

    drv(1, LSU_SH, 32'h6, 32'h1234, 0);
    chk("sh_wen", 32'(ram_wen), 32'hC);
    chk("sh_wdata", ram_wdata, 32'h12341234);
    chk("sh_addr", 32'(ram_addr), 1);
    tick;
    chk("sh_valid", 32'(rsp_valid), 1);
    chk("sh_rdata", rsp_rdata, 0);

    drv(1, LSU_LW, 32'h4, 0, 0);
    tick;
    chk("raw_hi", 32'(rsp_rdata[31:16]), 32'h1234);
    chk("raw_word", rsp_rdata, 32'h12347788);

    drv(1, LSU_SB, 32'h3, 32'hCD, 0);
    chk("sb_wen", 32'(ram_wen), 32'h8);
    chk("sb_wdata", ram_wdata, 32'hCDCDCDCD);
    tick;
    drv(1, LSU_LB, 32'h3, 0, 0);
    tick;
    chk("lb3_data", rsp_rdata, 32'hFFFFFFCD);

    drv(0, LSU_LB, 0, 0, 0);
    tick;
    chk("idle_valid", 32'(rsp_valid), 0);

    drv(1, LSU_LW, 32'h2, 0, 0);
    chk("adel_en", 32'(ram_en), 0);
    tick;
    chk("adel_exc", 32'(exc_valid), 1);
    chk("adel_code", 32'(exc_code), 1);
    chk("adel_bad", exc_badvaddr, 32'h2);
    chk("adel_ready", 32'(req_ready), 0);
    chk("adel_rsp", 32'(rsp_valid), 0);
    drv(1, LSU_LW, 32'h0, 0, 0);
    chk("exc_block_en", 32'(ram_en), 0);
    tick;
    chk("exc_pulse", 32'(exc_valid), 0);
    chk("exc_hold_ready", 32'(req_ready), 0);
    chk("exc_hold_code", 32'(exc_code), 1);
    drv(0, LSU_LB, 0, 0, 1);
    tick;
    chk("flush_ready", 32'(req_ready), 1);

    drv(1, LSU_SW, 32'h194, 32'h1, 0);
    chk("range_en", 32'(ram_en), 0);
    tick;
    chk("range_exc", 32'(exc_valid), 1);
    chk("range_code", 32'(exc_code), 3);
    chk("range_bad", exc_badvaddr, 32'h194);
    drv(0, LSU_LB, 0, 0, 1);
    tick;
    drv(1, LSU_SH, 32'h195, 32'h1, 0);
    tick;
    chk("ades_code", 32'(exc_code), 2);
    chk("ades_bad", exc_badvaddr, 32'h195);
    drv(0, LSU_LB, 0, 0, 1);
    tick;

    drv(1, LSU_SW, 32'h190, 32'hDEADBEEF, 0);
    chk("top_en", 32'(ram_en), 1);
    chk("top_addr", 32'(ram_addr), 100);
    chk("top_wen", 32'(ram_wen), 32'hF);
    tick;
    drv(1, LSU_LW, 32'h190, 0, 0);
    tick;
    chk("top_data", rsp_rdata, 32'hDEADBEEF);

    drv(1, LSU_LW, 32'h0, 0, 0);
    tick;
    chk("b2b0_valid", 32'(rsp_valid), 1);
    chk("b2b0_data", rsp_rdata, 32'hCD99AABB);
    drv(1, LSU_LW, 32'h4, 0, 0);
    tick;
    chk("b2b1_valid", 32'(rsp_valid), 1);
    chk("b2b1_data", rsp_rdata, 32'h12347788);
    drv(1, LSU_LW, 32'h8, 0, 0);
    tick;
    chk("b2b2_valid", 32'(rsp_valid), 1);
    chk("b2b2_data", rsp_rdata, 32'h0BADF00D);
    drv(1, LSU_LW, 32'hC, 0, 0);
    tick;
    chk("b2b3_valid", 32'(rsp_valid), 1);
    chk("b2b3_data", rsp_rdata, 32'hCAFEBABE);
    drv(0, LSU_LB, 0, 0, 0);
    tick;
    chk("b2b_end", 32'(rsp_valid), 0);

    drv(1, LSU_LW, 32'h8, 0, 0);
    tick;
    drv(0, LSU_LB, 0, 0, 1);
    chk("flush_sq", 32'(rsp_valid), 0);
    tick;
    drv(0, LSU_LB, 0, 0, 0);
    chk("flush_after", 32'(rsp_valid), 0);

    drv(1, LSU_LW, 32'h4, 0, 0);
    tick;
    drv(1, LSU_LW, 32'hC, 0, 1);
    chk("flushreq_sq", 32'(rsp_valid), 0);
    chk("flushreq_en", 32'(ram_en), 1);
    tick;
    drv(0, LSU_LB, 0, 0, 0);
    chk("flushreq_valid", 32'(rsp_valid), 1);
    chk("flushreq_data", rsp_rdata, 32'hCAFEBABE);

    drv(1, LSU_LW, 32'h0, 0, 0);
    tick;
    resetn = 1'b0;
    drv(0, LSU_LB, 0, 0, 0);
    chk("rbusy_rsp", 32'(rsp_valid), 0);
    chk("rbusy_rdata", rsp_rdata, 0);
    chk("rbusy_code", 32'(exc_code), 0);
    chk("rbusy_bad", exc_badvaddr, 0);
    chk("rbusy_exc", 32'(exc_valid), 0);
    chk("rbusy_en", 32'(ram_en), 0);
    chk("rbusy_wen", 32'(ram_wen), 0);
    tick;
    resetn = 1'b1;
    tick;
    chk("rbusy_post_rsp", 32'(rsp_valid), 0);
    chk("rbusy_post_rdy", 32'(req_ready), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
